// File: rtl/vga_scan_driver.sv
// -----------------------------------------------------------------------------
// vga_scan_driver
//
// Generates the 640x480@60 VGA raster.
// - A horizontal counter and a vertical counter walk the whole frame,
//   including the porches and the sync pulses.
// - col/row/active are decoded combinationally and go to the level renderers.
// - The renderer colour comes back PIPE_DELAY cycles later. It is blanked and
//   registered together with hsync/vsync, so all connector signals stay
//   aligned.
// - frame_tick and frame_count pace the game logic. They are undelayed and
//   belong to the raster domain.
//
// Ports:
//   pixel_clk    in   pixel clock (25 MHz nominal)
//   resetSwitch  in   asynchronous active-low reset
//   col          out  [9:0] visible column, 0 outside the visible area
//   row          out  [8:0] visible row, 0 outside the visible area
//   active       out  col/row lie in the visible area
//   red_in       in   [3:0] renderer red, valid PIPE_DELAY cycles after col/row
//   green_in     in   [3:0] renderer green
//   blue_in      in   [3:0] renderer blue
//   vga_red      out  [3:0] registered, blanked red to the connector
//   vga_green    out  [3:0] registered, blanked green to the connector
//   vga_blue     out  [3:0] registered, blanked blue to the connector
//   hsync        out  registered, active-low
//   vsync        out  registered, active-low
//   frame_tick   out  one-cycle pulse at the first cycle of vertical blanking
//   frame_count  out  [7:0] frames completed, wrapping
// -----------------------------------------------------------------------------
module vga_scan_driver #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int PIPE_DELAY = 1
) (
    input  logic       pixel_clk,
    input  logic       resetSwitch,
    output logic [9:0] col,
    output logic [8:0] row,
    output logic       active,
    input  logic [3:0] red_in,
    input  logic [3:0] green_in,
    input  logic [3:0] blue_in,
    output logic [3:0] vga_red,
    output logic [3:0] vga_green,
    output logic [3:0] vga_blue,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_tick,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_STOP  = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_STOP  = 10'(V_ACTIVE + V_FP + V_SYNC);

    // The delay line must be 1-4 deep. Both totals must fit the 10-bit
    // counters.
    if (PIPE_DELAY < 1 || PIPE_DELAY > 4 || H_TOTAL > 1023 || V_TOTAL > 1023) begin : g_param_guard
        $error("vga_scan_driver: PIPE_DELAY must be 1-4 and H_TOTAL/V_TOTAL must not exceed 1023");
    end

    logic [9:0]            r_h_cnt;
    logic [9:0]            r_v_cnt;
    logic                  w_h_vis;
    logic                  w_v_vis;
    logic                  w_active;
    logic                  w_hs_raw;
    logic                  w_vs_raw;
    logic                  w_frame_start;
    logic [PIPE_DELAY-1:0] r_act_dly;
    logic [PIPE_DELAY-1:0] r_hs_dly;
    logic [PIPE_DELAY-1:0] r_vs_dly;
    logic [3:0]            r_red;
    logic [3:0]            r_green;
    logic [3:0]            r_blue;
    logic                  r_hsync;
    logic                  r_vsync;
    logic [7:0]            r_frame_count;

    // Raster counters: v advances only on the h wrap.
    always_ff @(posedge pixel_clk or negedge resetSwitch) begin
        if (!resetSwitch) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == V_LAST) ? 10'd0 : r_v_cnt + 10'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 10'd1;
        end
    end

    assign w_h_vis  = (r_h_cnt < H_VIS);
    assign w_v_vis  = (r_v_cnt < V_VIS);
    assign w_active = w_h_vis && w_v_vis;

    // row is forced to 0 in vertical blanking. Otherwise lines 512-524 would
    // alias onto rows 0-12 in 9 bits.
    assign col    = w_h_vis ? r_h_cnt : 10'd0;
    assign row    = w_v_vis ? r_v_cnt[8:0] : 9'd0;
    assign active = w_active;

    assign w_hs_raw = !((r_h_cnt >= HS_START) && (r_h_cnt < HS_STOP));
    assign w_vs_raw = !((r_v_cnt >= VS_START) && (r_v_cnt < VS_STOP));

    assign w_frame_start = (r_h_cnt == 10'd0) && (r_v_cnt == V_VIS);

    // Delay line that matches renderer latency. In reset, sync is inactive
    // (high) and the blank state is active (colour off).
    always_ff @(posedge pixel_clk or negedge resetSwitch) begin
        if (!resetSwitch) begin
            r_act_dly <= '0;
            r_hs_dly  <= '1;
            r_vs_dly  <= '1;
        end else begin
            r_act_dly[0] <= w_active;
            r_hs_dly[0]  <= w_hs_raw;
            r_vs_dly[0]  <= w_vs_raw;
            for (int i = 1; i < PIPE_DELAY; i++) begin
                r_act_dly[i] <= r_act_dly[i-1];
                r_hs_dly[i]  <= r_hs_dly[i-1];
                r_vs_dly[i]  <= r_vs_dly[i-1];
            end
        end
    end

    // Connector register: colour, blank and sync leave on the same edge.
    always_ff @(posedge pixel_clk or negedge resetSwitch) begin
        if (!resetSwitch) begin
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
        end else begin
            r_red   <= r_act_dly[PIPE_DELAY-1] ? red_in   : 4'd0;
            r_green <= r_act_dly[PIPE_DELAY-1] ? green_in : 4'd0;
            r_blue  <= r_act_dly[PIPE_DELAY-1] ? blue_in  : 4'd0;
            r_hsync <= r_hs_dly[PIPE_DELAY-1];
            r_vsync <= r_vs_dly[PIPE_DELAY-1];
        end
    end

    always_ff @(posedge pixel_clk or negedge resetSwitch) begin
        if (!resetSwitch) begin
            r_frame_count <= '0;
        end else if (w_frame_start) begin
            r_frame_count <= r_frame_count + 8'd1;
        end
    end

    assign vga_red     = r_red;
    assign vga_green   = r_green;
    assign vga_blue    = r_blue;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign frame_tick  = w_frame_start;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_vga_scan_driver
//
// Drives two copies of vga_scan_driver from one clock, one reset and one set
// of colour inputs:
//   dut 0: the real 640x480 timing with PIPE_DELAY=1.
//   dut 1: a tiny raster (14x11) with PIPE_DELAY=3, so that many whole frames
//          and a frame_count wrap fit into a short run.
// Outputs are sampled on the falling edge. Cycle n counts falling edges since
// the release of reset; cycle 0 is the one right after release.
// -----------------------------------------------------------------------------
module tb_vga_scan_driver;

    localparam int HA [2] = '{640, 8};
    localparam int HF [2] = '{16, 1};
    localparam int HS [2] = '{96, 3};
    localparam int HB [2] = '{48, 2};
    localparam int VA [2] = '{480, 6};
    localparam int VF [2] = '{10, 1};
    localparam int VS [2] = '{2, 2};
    localparam int VB [2] = '{33, 2};
    localparam int PD [2] = '{1, 3};

    logic       pixel_clk   = 1'b0;
    logic       resetSwitch = 1'b0;
    logic [3:0] red_in      = 4'd0;
    logic [3:0] green_in    = 4'd0;
    logic [3:0] blue_in     = 4'd0;

    logic [9:0] o_col [2];
    logic [8:0] o_row [2];
    logic       o_act [2];
    logic [3:0] o_r   [2];
    logic [3:0] o_g   [2];
    logic [3:0] o_b   [2];
    logic       o_hs  [2];
    logic       o_vs  [2];
    logic       o_tick[2];
    logic [7:0] o_fc  [2];

    int n      = 0;
    int errors = 0;
    int checks = 0;

    always #5 pixel_clk = ~pixel_clk;

    vga_scan_driver #(
        .H_ACTIVE(HA[0]), .H_FP(HF[0]), .H_SYNC(HS[0]), .H_BP(HB[0]),
        .V_ACTIVE(VA[0]), .V_FP(VF[0]), .V_SYNC(VS[0]), .V_BP(VB[0]),
        .PIPE_DELAY(PD[0])
    ) u_dut0 (
        .pixel_clk(pixel_clk), .resetSwitch(resetSwitch),
        .col(o_col[0]), .row(o_row[0]), .active(o_act[0]),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .vga_red(o_r[0]), .vga_green(o_g[0]), .vga_blue(o_b[0]),
        .hsync(o_hs[0]), .vsync(o_vs[0]),
        .frame_tick(o_tick[0]), .frame_count(o_fc[0])
    );

    vga_scan_driver #(
        .H_ACTIVE(HA[1]), .H_FP(HF[1]), .H_SYNC(HS[1]), .H_BP(HB[1]),
        .V_ACTIVE(VA[1]), .V_FP(VF[1]), .V_SYNC(VS[1]), .V_BP(VB[1]),
        .PIPE_DELAY(PD[1])
    ) u_dut1 (
        .pixel_clk(pixel_clk), .resetSwitch(resetSwitch),
        .col(o_col[1]), .row(o_row[1]), .active(o_act[1]),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .vga_red(o_r[1]), .vga_green(o_g[1]), .vga_blue(o_b[1]),
        .hsync(o_hs[1]), .vsync(o_vs[1]),
        .frame_tick(o_tick[1]), .frame_count(o_fc[1])
    );

    // ---------------- reference model (raster arithmetic) ----------------
    function automatic int htot(int d);
        return HA[d] + HF[d] + HS[d] + HB[d];
    endfunction

    function automatic int vtot(int d);
        return VA[d] + VF[d] + VS[d] + VB[d];
    endfunction

    function automatic int ftot(int d);
        return htot(d) * vtot(d);
    endfunction

    function automatic int hpos(int d, int k);
        return k % htot(d);
    endfunction

    function automatic int vpos(int d, int k);
        return (k / htot(d)) % vtot(d);
    endfunction

    // Packed layout, LSB first:
    //   fc[7:0] b[11:8] g[15:12] r[19:16] tick[20] vs[21] hs[22] act[23]
    //   row[32:24] col[42:33]
    // The model must be called at cycle k of a continuous run from release.
    // The colour it expects is whatever the bench currently drives, because
    // that is the value captured on the edge that opens cycle k.
    function automatic logic [42:0] exp_vec(int d, int k);
        int h, v, m, hm, vm, c, rw, fc, t0;
        logic a, hsv, vsv, tk;
        logic [11:0] rgb;
        h   = hpos(d, k);
        v   = vpos(d, k);
        c   = (h < HA[d]) ? h : 0;
        rw  = (v < VA[d]) ? v : 0;
        a   = (h < HA[d]) && (v < VA[d]);
        tk  = (h == 0) && (v == VA[d]);
        hsv = 1'b1;
        vsv = 1'b1;
        rgb = 12'h000;
        m   = k - PD[d] - 1;
        if (m >= 0) begin
            hm  = hpos(d, m);
            vm  = vpos(d, m);
            hsv = !(hm >= HA[d] + HF[d] && hm < HA[d] + HF[d] + HS[d]);
            vsv = !(vm >= VA[d] + VF[d] && vm < VA[d] + VF[d] + VS[d]);
            if (hm < HA[d] && vm < VA[d]) rgb = {red_in, green_in, blue_in};
        end
        t0 = VA[d] * htot(d);
        fc = (k <= t0) ? 0 : (((k - 1 - t0) / ftot(d) + 1) % 256);
        return {10'(c), 9'(rw), a, hsv, vsv, tk, rgb, 8'(fc)};
    endfunction

    function automatic logic [42:0] obs_vec(int d);
        return {o_col[d], o_row[d], o_act[d], o_hs[d], o_vs[d], o_tick[d],
                o_r[d], o_g[d], o_b[d], o_fc[d]};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic adv(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        red_in   = r;
        green_in = g;
        blue_in  = b;
        @(negedge pixel_clk);
        n++;
    endtask

    task automatic adv_rand();
        adv(4'($urandom_range(15)), 4'($urandom_range(15)), 4'($urandom_range(15)));
    endtask

    task automatic pulse_reset();
        @(negedge pixel_clk);
        resetSwitch = 1'b0;
        @(negedge pixel_clk);
        @(negedge pixel_clk);
        resetSwitch = 1'b1;
        n = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [42:0] ob, ev;
        red_in   = 4'hF;
        green_in = 4'hF;
        blue_in  = 4'hF;
        @(negedge pixel_clk);
        @(negedge pixel_clk);
        for (int d = 0; d < 2; d++) begin
            ob = obs_vec(d);
            checks++;
            if ({ob[42:24], ob[22:0]} !== {19'd0, 2'b11, 21'd0}) begin
                errors++;
                $display("FAIL reset_hold dut%0d got=%h want col/row=0 hs=vs=1 tick=0 rgb=0 fc=0", d, ob);
            end
        end
        resetSwitch = 1'b1;
        n = 0;
        for (int d = 0; d < 2; d++) begin
            ob = obs_vec(d);
            ev = exp_vec(d, n);
            checks++;
            if (ob !== ev) begin
                errors++;
                $display("FAIL reset_release dut%0d got=%h exp=%h", d, ob, ev);
            end
            checks++;
            if (o_act[d] !== 1'b1) begin
                errors++;
                $display("FAIL first_active dut%0d got=%b exp=1", d, o_act[d]);
            end
        end
    endtask

    task automatic test_raster_random(input int ncyc);
        logic [42:0] ob, ev;
        for (int i = 0; i < ncyc; i++) begin
            for (int d = 0; d < 2; d++) begin
                ob = obs_vec(d);
                ev = exp_vec(d, n);
                checks++;
                if (ob !== ev) begin
                    errors++;
                    $display("FAIL raster dut%0d cycle=%0d got=%h exp=%h", d, n, ob, ev);
                end
            end
            adv_rand();
        end
    endtask

    task automatic test_colour_hold(input int ncyc);
        logic [42:0] ob, ev;
        for (int i = 0; i < ncyc; i++) begin
            for (int d = 0; d < 2; d++) begin
                ob = obs_vec(d);
                ev = exp_vec(d, n);
                checks++;
                if (ob[19:8] !== ev[19:8]) begin
                    errors++;
                    $display("FAIL colour_hold dut%0d cycle=%0d got=%h exp=%h", d, n, ob[19:8], ev[19:8]);
                end
            end
            adv(4'hF, 4'h0, 4'hA);
        end
    endtask

    task automatic test_frame_wrap();
        logic [42:0] ob, ev;
        int last_tick, vs_fall, vs_low, stop;
        logic [7:0] prev_fc;
        logic prev_vs, wrap_seen;
        last_tick = -1;
        vs_fall   = -1;
        vs_low    = 0;
        wrap_seen = 1'b0;
        prev_fc   = o_fc[1];
        prev_vs   = o_vs[1];
        stop      = n + 257 * ftot(1) + 50;
        while (n < stop) begin
            ob = obs_vec(1);
            ev = exp_vec(1, n);
            checks++;
            if ({ob[21:20], ob[7:0]} !== {ev[21:20], ev[7:0]}) begin
                errors++;
                $display("FAIL frame vs/tick/fc cycle=%0d got=%h exp=%h", n, {ob[21:20], ob[7:0]}, {ev[21:20], ev[7:0]});
            end
            if (o_tick[1] === 1'b1) begin
                if (last_tick >= 0) begin
                    checks++;
                    if (n - last_tick != ftot(1)) begin
                        errors++;
                        $display("FAIL tick_spacing got=%0d exp=%0d", n - last_tick, ftot(1));
                    end
                end
                last_tick = n;
            end
            if (prev_vs === 1'b1 && o_vs[1] === 1'b0) begin
                if (vs_fall >= 0) begin
                    checks++;
                    if (n - vs_fall != ftot(1)) begin
                        errors++;
                        $display("FAIL vsync_period got=%0d exp=%0d", n - vs_fall, ftot(1));
                    end
                end
                vs_fall = n;
                vs_low  = 0;
            end
            if (o_vs[1] === 1'b0) vs_low++;
            if (prev_vs === 1'b0 && o_vs[1] === 1'b1 && vs_fall >= 0) begin
                checks++;
                if (vs_low != VS[1] * htot(1)) begin
                    errors++;
                    $display("FAIL vsync_width got=%0d exp=%0d", vs_low, VS[1] * htot(1));
                end
            end
            if (prev_fc === 8'hFF && o_fc[1] === 8'h00) wrap_seen = 1'b1;
            prev_fc = o_fc[1];
            prev_vs = o_vs[1];
            adv_rand();
        end
        checks++;
        if (wrap_seen !== 1'b1) begin
            errors++;
            $display("FAIL frame_count_wrap got=%b exp=1", wrap_seen);
        end
    endtask

    task automatic test_async_reset();
        logic [42:0] ob, ev;
        int pix, line;
        logic [9:0] ecol;
        logic [8:0] erow;
        logic eact;
        pulse_reset();
        while (n < 700) adv_rand();
        // Here dut0 is at h_cnt=700 of line 0, in the middle of its hsync pulse.
        for (int d = 0; d < 2; d++) begin
            ev = exp_vec(d, n);
            checks++;
            if (o_hs[d] !== ev[22] || ev[22] !== 1'b0) begin
                errors++;
                $display("FAIL mid_hsync dut%0d got=%b model=%b exp=0", d, o_hs[d], ev[22]);
            end
        end
        red_in   = 4'hF;
        green_in = 4'hF;
        blue_in  = 4'hF;
        @(posedge pixel_clk);
        #2;
        resetSwitch = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            ob = obs_vec(d);
            checks++;
            if ({ob[42:24], ob[22:21], ob[19:0]} !== {19'd0, 2'b11, 20'd0}) begin
                errors++;
                $display("FAIL async_reset dut%0d got=%h want col/row=0 hs=vs=1 rgb=0 fc=0", d, ob);
            end
        end
        @(negedge pixel_clk);
        @(negedge pixel_clk);
        for (int d = 0; d < 2; d++) begin
            ob = obs_vec(d);
            checks++;
            if ({ob[42:24], ob[22:0]} !== {19'd0, 2'b11, 21'd0}) begin
                errors++;
                $display("FAIL async_reset_hold dut%0d got=%h", d, ob);
            end
        end
        resetSwitch = 1'b1;
        n = 0;
        for (int i = 0; i < 810; i++) begin
            pix  = n % 800;
            line = n / 800;
            ecol = (pix < 640) ? 10'(pix) : 10'd0;
            erow = 9'(line);
            eact = (pix < 640);
            checks++;
            if ({o_col[0], o_row[0], o_act[0]} !== {ecol, erow, eact}) begin
                errors++;
                $display("FAIL restart cycle=%0d got col=%0d row=%0d act=%b exp col=%0d row=%0d act=%b",
                         n, o_col[0], o_row[0], o_act[0], ecol, erow, eact);
            end
            adv_rand();
        end
    endtask

    task automatic test_hsync_pulse();
        int fall, rise;
        logic prev_hs;
        pulse_reset();
        fall    = -1;
        rise    = -1;
        prev_hs = o_hs[0];
        for (int i = 0; i < 900; i++) begin
            if (prev_hs === 1'b1 && o_hs[0] === 1'b0 && fall < 0) fall = n;
            if (prev_hs === 1'b0 && o_hs[0] === 1'b1 && fall >= 0 && rise < 0) rise = n;
            if (o_hs[0] === 1'b0) begin
                checks++;
                if ({o_r[0], o_g[0], o_b[0]} !== 12'h000) begin
                    errors++;
                    $display("FAIL hsync_blank cycle=%0d got=%h exp=000", n, {o_r[0], o_g[0], o_b[0]});
                end
            end
            prev_hs = o_hs[0];
            adv_rand();
        end
        checks++;
        if (fall != 658) begin
            errors++;
            $display("FAIL hsync_fall got=%0d exp=658", fall);
        end
        checks++;
        if (rise != 754) begin
            errors++;
            $display("FAIL hsync_rise got=%0d exp=754", rise);
        end
        checks++;
        if (rise - fall != 96) begin
            errors++;
            $display("FAIL hsync_width got=%0d exp=96", rise - fall);
        end
    endtask

    initial begin
        test_reset();
        test_raster_random(1700);
        test_colour_hold(1700);
        test_frame_wrap();
        test_async_reset();
        test_hsync_pulse();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
